// File: rtl/rv0_ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package rv0_ifu_fetch_pkg;

    localparam int unsigned RV0_XLEN     = 32;
    localparam int unsigned RV0_FLEN     = 32;
    localparam int unsigned INSN_W       = 32;
    localparam int unsigned IALIGN_BYTES = 4;

    // One buffered fetch result: the word and the address it came from.
    typedef struct packed {
        logic [RV0_XLEN-1:0] addr;
        logic [INSN_W-1:0]   insn;
    } ifu_entry_t;

endpackage

// File: rtl/rv_sbuf_if.sv
// Skid-buffer style handshake carrying one decoded-stage packet per transfer.
interface rv_sbuf_if #(
    parameter int unsigned XLEN = 32
);
    logic [31:0]     insn;
    logic [XLEN-1:0] addr;
    logic            rdy;
    logic [XLEN-1:0] idata1;
    logic [XLEN-1:0] idata2;
    logic            ack;

    modport source (output insn, output addr, output rdy, output idata1, output idata2, input ack);
    modport sink   (input insn, input addr, input rdy, input idata1, input idata2, output ack);
endinterface

// File: rtl/rv0_ifu_fifo.sv
// Small synchronous FIFO with flush; DEPTH must be a power of two.
module rv0_ifu_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW   = $clog2(DEPTH),
    localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CW-1:0]    count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             push_ok;
    logic             pop_ok;

    // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;
    assign count_o = count;
    assign full_o  = (count == CW'(DEPTH));
    assign empty_o = (count == '0);
    assign rdata_o = mem[rd_ptr];

    // Storage array needs no reset; the occupancy count guards every read.
    always_ff @(posedge clk_i) begin
        if (push_ok && !flush_i) begin
            mem[wr_ptr] <= wdata_i;
        end
    end

    // Pointer and occupancy tracking; flush empties the FIFO in one cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

endmodule

// File: rtl/rv0_ifu_fetch.sv
// Instruction fetch front end: PC, credit-limited word fetches, response buffer and redirect handling.
module rv0_ifu_fetch
    import rv0_ifu_fetch_pkg::*;
#(
    parameter int unsigned     XLEN       = RV0_XLEN,
    parameter int unsigned     FLEN       = RV0_FLEN,
    parameter logic [XLEN-1:0] RESET_ADDR = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic [XLEN-1:0] ifu_fc_target_i,
    input  logic            ifu_fc_trans_i,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_gnt_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    rv_sbuf_if.source       ifu_sbuf_if
);

    localparam int unsigned     CW         = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned     EW         = $bits(ifu_entry_t);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(IALIGN_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(IALIGN_BYTES - 1));
    localparam logic [CW:0]     CREDIT_MAX = (CW + 1)'(FIFO_DEPTH);

    // The buffered entry layout is shared with decode, so the address width must agree with it.
    if (XLEN != RV0_XLEN || FLEN == 0 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
        $error("rv0_ifu_fetch: unsupported parameter combination");
    end

    logic [XLEN-1:0] pc;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   dsc_cnt;
    logic [CW-1:0]   ififo_cnt;
    logic [XLEN-1:0] afifo_head;
    logic            afifo_full;
    logic            afifo_empty;
    logic            ififo_full;
    logic            ififo_empty;
    ifu_entry_t      ififo_wdata;
    ifu_entry_t      ififo_head;
    logic            credit_ok;
    logic            grant;
    logic            resp;
    logic            resp_keep;
    logic            deliver;

    // Outstanding fetches plus buffered words may never exceed the buffer depth, so responses always fit.
    assign credit_ok   = ({1'b0, out_cnt} + {1'b0, ififo_cnt}) < CREDIT_MAX;
    assign imem_req_o  = rst_ni && credit_ok && !ifu_fc_trans_i;
    assign imem_addr_o = pc;
    assign grant       = imem_req_o && imem_gnt_i;

    // Responses with nothing outstanding are stale (e.g. from before a reset) and are ignored.
    assign resp        = imem_rvalid_i && !afifo_empty;
    assign resp_keep   = resp && (dsc_cnt == '0) && !ifu_fc_trans_i;
    assign ififo_wdata = {afifo_head, imem_rdata_i};

    assign ifu_sbuf_if.rdy    = !ififo_empty && !ifu_fc_trans_i;
    assign ifu_sbuf_if.insn   = ififo_empty ? '0 : ififo_head.insn;
    assign ifu_sbuf_if.addr   = ififo_empty ? '0 : ififo_head.addr;
    assign ifu_sbuf_if.idata1 = '0;
    assign ifu_sbuf_if.idata2 = '0;
    assign deliver            = ifu_sbuf_if.rdy && ifu_sbuf_if.ack;

    // Program counter: redirect target (word aligned) wins, otherwise advance on each accepted fetch.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc <= RESET_ADDR;
        end else if (ifu_fc_trans_i) begin
            pc <= ifu_fc_target_i & ALIGN_MASK;
        end else if (grant) begin
            pc <= pc + PC_STEP;
        end
    end

    // Discard counter: on redirect every fetch still in flight after this cycle must be thrown away.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dsc_cnt <= '0;
        end else if (ifu_fc_trans_i) begin
            dsc_cnt <= out_cnt - CW'(resp);
        end else if (resp && (dsc_cnt != '0)) begin
            dsc_cnt <= dsc_cnt - 1'b1;
        end
    end

    // Addresses of in-flight fetches; its occupancy is the outstanding count. Never flushed on redirect.
    rv0_ifu_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_afifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (grant),
        .pop_i   (resp),
        .flush_i (1'b0),
        .wdata_i (pc),
        .rdata_o (afifo_head),
        .count_o (out_cnt),
        .full_o  (afifo_full),
        .empty_o (afifo_empty)
    );

    // Fetched {addr, insn} pairs waiting for decode; dropped wholesale on redirect.
    rv0_ifu_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_ififo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (resp_keep),
        .pop_i   (deliver),
        .flush_i (ifu_fc_trans_i),
        .wdata_i (ififo_wdata),
        .rdata_o (ififo_head),
        .count_o (ififo_cnt),
        .full_o  (ififo_full),
        .empty_o (ififo_empty)
    );

`ifndef SYNTHESIS
    a_dsc_le_out: assert property (@(posedge clk_i) disable iff (!rst_ni) dsc_cnt <= out_cnt);
    a_no_stray_rvalid: assert property (@(posedge clk_i) disable iff (!rst_ni) imem_rvalid_i |-> !afifo_empty);
    a_afifo_no_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni) grant |-> !afifo_full);
    a_ififo_no_ovf: assert property (@(posedge clk_i) disable iff (!rst_ni) (resp_keep && ififo_full) |-> deliver);
`endif

endmodule

// File: tb/tb_rv0_ifu_fetch.sv
// Randomised bench for rv0_ifu_fetch with a queue-based reference model and directed scenarios.
module tb_rv0_ifu_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] fc_target;
    logic        fc_trans;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    rv_sbuf_if #(.XLEN(32)) sbuf ();

    rv0_ifu_fetch #(
        .XLEN       (32),
        .FLEN       (32),
        .RESET_ADDR (32'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .ifu_fc_target_i (fc_target),
        .ifu_fc_trans_i  (fc_trans),
        .imem_req_o      (imem_req),
        .imem_addr_o     (imem_addr),
        .imem_gnt_i      (imem_gnt),
        .imem_rvalid_i   (imem_rvalid),
        .imem_rdata_i    (imem_rdata),
        .ifu_sbuf_if     (sbuf)
    );

    always #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    int cyc      = 0;

    // reference model: PC, in-flight fetches with a drop flag, buffered {addr,insn}
    logic [31:0] m_pc;
    logic [31:0] m_out_addr[$];
    bit          m_out_drop[$];
    logic [63:0] m_buf[$];

    // memory environment: in-order pending responses
    logic [31:0] env_addr[$];
    int          env_due[$];
    int          env_last_due;
    int          lat_min;
    int          lat_max;
    int          grant_cnt;

    // words observed leaving the DUT
    logic [31:0] dlv_addr[$];
    logic [31:0] dlv_insn[$];

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    function automatic logic [31:0] dlvAddrAt(input int i);
        return (dlv_addr.size() > i) ? dlv_addr[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] dlvInsnAt(input int i);
        return (dlv_insn.size() > i) ? dlv_insn[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clearLog();
        dlv_addr.delete();
        dlv_insn.delete();
        grant_cnt = 0;
    endtask

    // Compare DUT against the model for the current cycle, then advance model and environment.
    task automatic checkOutput();
        bit          exp_req;
        bit          exp_rdy;
        logic [63:0] head;
        logic [31:0] a;
        bit          d;
        int          due;
        exp_req = ((m_out_addr.size() + m_buf.size()) < DEPTH) && !fc_trans;
        exp_rdy = (m_buf.size() > 0) && !fc_trans;
        head    = (m_buf.size() > 0) ? m_buf[0] : 64'h0;
        checkVal("imem_req", 64'(imem_req), 64'(exp_req));
        checkVal("imem_addr", 64'(imem_addr), 64'(m_pc));
        checkVal("sbuf_rdy", 64'(sbuf.rdy), 64'(exp_rdy));
        checkVal("sbuf_addr", 64'(sbuf.addr), 64'(head[63:32]));
        checkVal("sbuf_insn", 64'(sbuf.insn), 64'(head[31:0]));
        checkVal("sbuf_idata", {sbuf.idata1, sbuf.idata2}, 64'h0);
        if (sbuf.rdy && sbuf.ack) begin
            dlv_addr.push_back(sbuf.addr);
            dlv_insn.push_back(sbuf.insn);
        end
        if (imem_req && imem_gnt) begin
            grant_cnt++;
            due = cyc + lat_min + int'($urandom_range(lat_max - lat_min, 0));
            if (due <= env_last_due) due = env_last_due + 1;
            env_addr.push_back(imem_addr);
            env_due.push_back(due);
            env_last_due = due;
        end
        if (exp_rdy && sbuf.ack) void'(m_buf.pop_front());
        if (imem_rvalid && (m_out_addr.size() > 0)) begin
            a = m_out_addr.pop_front();
            d = m_out_drop.pop_front();
            if (!d && !fc_trans) m_buf.push_back({a, memWord(a)});
        end
        if (fc_trans) begin
            foreach (m_out_drop[i]) m_out_drop[i] = 1'b1;
            m_buf.delete();
            m_pc = fc_target & ~32'h3;
        end else if (exp_req && imem_gnt) begin
            m_out_addr.push_back(m_pc);
            m_out_drop.push_back(1'b0);
            m_pc = m_pc + 32'd4;
        end
    endtask

    // Drive one cycle of inputs just after the clock edge, then check at the falling edge.
    task automatic applyStimulus(input bit fc, input logic [31:0] tgt, input bit gnt, input bit ack);
        @(posedge clk);
        #1;
        fc_trans  = fc;
        fc_target = tgt;
        imem_gnt  = gnt;
        sbuf.ack  = ack;
        if ((env_due.size() > 0) && (env_due[0] == cyc)) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memWord(env_addr[0]);
            void'(env_addr.pop_front());
            void'(env_due.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        @(negedge clk);
        checkOutput();
        cyc++;
    endtask

    // Asynchronous reset pulse mid-cycle; outputs must take reset values immediately.
    task automatic doReset();
        @(posedge clk);
        #3;
        rst_n       = 1'b0;
        fc_trans    = 1'b0;
        fc_target   = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        sbuf.ack    = 1'b0;
        #1;
        checkVal("rst_req", 64'(imem_req), 64'h0);
        checkVal("rst_addr", 64'(imem_addr), 64'h0);
        checkVal("rst_rdy", 64'(sbuf.rdy), 64'h0);
        checkVal("rst_insn", 64'(sbuf.insn), 64'h0);
        checkVal("rst_sbuf_addr", 64'(sbuf.addr), 64'h0);
        m_pc = 32'h0;
        m_out_addr.delete();
        m_out_drop.delete();
        m_buf.delete();
        env_addr.delete();
        env_due.delete();
        env_last_due = cyc;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b1;
        fc_trans    = 1'b0;
        fc_target   = '0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        sbuf.ack    = 1'b0;
        lat_min     = 1;
        lat_max     = 1;
        env_last_due = 0;
        m_pc        = '0;
        grant_cnt   = 0;

        // sequential fetch, 1-cycle memory, decode always accepting
        doReset();
        clearLog();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkVal("t1_first_req", 64'(imem_req), 64'h1);
        checkVal("t1_first_addr", 64'(imem_addr), 64'h0);
        repeat (11) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkVal("t1_addr0", 64'(dlvAddrAt(0)), 64'h0);
        checkVal("t1_addr1", 64'(dlvAddrAt(1)), 64'h4);
        checkVal("t1_addr2", 64'(dlvAddrAt(2)), 64'h8);
        checkVal("t1_addr3", 64'(dlvAddrAt(3)), 64'hC);
        checkVal("t1_insn0", 64'(dlvInsnAt(0)), 64'h5A5AC3C3);
        checkVal("t1_insn1", 64'(dlvInsnAt(1)), 64'h5A5EC3C3);
        checkVal("t1_insn2", 64'(dlvInsnAt(2)), 64'h5A52C3C3);
        checkVal("t1_insn3", 64'(dlvInsnAt(3)), 64'h5A56C3C3);

        // decode stalled: only FIFO_DEPTH fetches, then hold
        doReset();
        clearLog();
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        checkVal("t2_grants", 64'(grant_cnt), 64'(DEPTH));
        checkVal("t2_req_low", 64'(imem_req), 64'h0);
        checkVal("t2_rdy", 64'(sbuf.rdy), 64'h1);
        checkVal("t2_head", 64'(sbuf.addr), 64'h0);
        repeat (6) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkVal("t2_addr0", 64'(dlvAddrAt(0)), 64'h0);
        checkVal("t2_addr1", 64'(dlvAddrAt(1)), 64'h4);
        checkVal("t2_addr2", 64'(dlvAddrAt(2)), 64'h8);

        // redirect with two fetches in flight
        doReset();
        lat_min = 4;
        lat_max = 4;
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        clearLog();
        applyStimulus(1'b1, 32'h200, 1'b1, 1'b1);
        lat_min = 1;
        lat_max = 1;
        repeat (15) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkVal("t3_addr0", 64'(dlvAddrAt(0)), 64'h200);
        checkVal("t3_insn0", 64'(dlvInsnAt(0)), 64'h585AC3C3);
        checkVal("t3_addr1", 64'(dlvAddrAt(1)), 64'h204);

        // redirect in the same cycle as a response, unaligned target
        doReset();
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        clearLog();
        applyStimulus(1'b1, 32'h103, 1'b0, 1'b0);
        checkVal("t4_rdy_fc", 64'(sbuf.rdy), 64'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        checkVal("t4_req", 64'(imem_req), 64'h1);
        checkVal("t4_req_addr", 64'(imem_addr), 64'h100);
        repeat (4) applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
        checkVal("t4_dropped", 64'(dlv_addr.size()), 64'h0);
        checkVal("t4_rdy_after", 64'(sbuf.rdy), 64'h0);

        // PC wraps at the top of the address space
        doReset();
        applyStimulus(1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        clearLog();
        repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkVal("t5_addr0", 64'(dlvAddrAt(0)), 64'hFFFF_FFFC);
        checkVal("t5_insn0", 64'(dlvInsnAt(0)), 64'hA5A63C3C);
        checkVal("t5_addr1", 64'(dlvAddrAt(1)), 64'h0);

        // reset with fetches in flight
        doReset();
        lat_min = 5;
        lat_max = 5;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        doReset();
        lat_min = 1;
        lat_max = 1;
        clearLog();
        repeat (10) applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
        checkVal("t6_addr0", 64'(dlvAddrAt(0)), 64'h0);
        checkVal("t6_addr1", 64'(dlvAddrAt(1)), 64'h4);

        // randomised traffic with redirects and an occasional reset
        doReset();
        lat_min = 1;
        lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) doReset();
            applyStimulus(($urandom_range(15, 0) == 0), $urandom,
                          ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
